// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and the IF/ID
// pipeline register, applying EX-stage redirects, stalls and memory wait states.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_alu_out,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        pc_misalign
);

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign redirect  = |npc_op;

    // jalr wins over jal/branch; jal and branch share the same PC-relative add.
    always_comb begin
        target_raw = ex_pc + ex_imm;
        if (npc_op[2]) begin
            target_raw = {ex_alu_out[31:1], 1'b0};
        end
    end

    assign target = {target_raw[31:2], 2'b00};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            pc_misalign <= 1'b0;
        end else begin
            pc_misalign <= 1'b0;
            if (redirect) begin
                pc          <= target;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                pc_misalign <= target_raw[1];
            end else if (stall) begin
                pc          <= pc;
            end else if (!imem_ready) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else begin
                pc          <= pc_plus4;
                if_id_pc    <= pc;
                if_id_pc4   <= pc_plus4;
                if_id_instr <= imem_rdata;
                if_id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: sequential fetch, stall, redirects,
// alignment, wrap-around, memory wait states and asynchronous reset.
module tb_if_stage;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic [2:0]  npc_op;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_alu_out;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        pc_misalign;

    int tests;
    int failed;
    logic [161:0] e;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .npc_op     (npc_op),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_alu_out (ex_alu_out),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .pc_misalign(pc_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h0020_0193;
            default: return a ^ 32'h5A5A_0003;
        endcase
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    // Layout: {imem_addr, pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, pc_misalign}
    function automatic logic [161:0] snap();
        return {imem_addr, pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, pc_misalign};
    endfunction

    function automatic logic [161:0] pack(input logic [31:0] p, input logic [31:0] ip,
                                          input logic [31:0] ip4, input logic [31:0] ins,
                                          input logic v, input logic m);
        return {p, p, ip, ip4, ins, v, m};
    endfunction

    task automatic clear_redirect();
        npc_op     = 3'b000;
        ex_pc      = '0;
        ex_imm     = '0;
        ex_alu_out = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        clear_redirect();
        @(negedge clk); @(negedge clk);
        e = pack(32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL reset got=%h exp=%h", snap(), e); end
    endtask

    task automatic test_sequential();
        rstn = 1'b1;
        @(negedge clk);
        e = pack(32'h4, 32'h0, 32'h4, 32'h0050_0093, 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL seq_0 got=%h exp=%h", snap(), e); end
        @(negedge clk);
        e = pack(32'h8, 32'h4, 32'h8, 32'h0010_0113, 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL seq_4 got=%h exp=%h", snap(), e); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = pack(32'h8, 32'h4, 32'h8, 32'h0010_0113, 1'b1, 1'b0);
            tests++; if (snap() !== e) begin failed++; $display("FAIL stall_%0d got=%h exp=%h", i, snap(), e); end
        end
        stall = 1'b0;
        @(negedge clk);
        e = pack(32'hC, 32'h8, 32'hC, 32'h0020_0193, 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL stall_resume8 got=%h exp=%h", snap(), e); end
        @(negedge clk);
        e = pack(32'h10, 32'hC, 32'h10, mem_word(32'hC), 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL stall_resumeC got=%h exp=%h", snap(), e); end
    endtask

    task automatic test_branch_over_stall();
        stall = 1'b1; npc_op = 3'b001; ex_pc = 32'h10; ex_imm = 32'hFFFF_FFF0;
        @(negedge clk);
        e = pack(32'h0, 32'hC, 32'h10, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL branch_stall got=%h exp=%h", snap(), e); end
        clear_redirect(); stall = 1'b0;
        @(negedge clk);
        e = pack(32'h4, 32'h0, 32'h4, 32'h0050_0093, 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL branch_after got=%h exp=%h", snap(), e); end
    endtask

    task automatic test_jalr_align();
        npc_op = 3'b100; ex_alu_out = 32'h103;
        @(negedge clk);
        e = pack(32'h100, 32'h0, 32'h4, 32'h13, 1'b0, 1'b1);
        tests++; if (snap() !== e) begin failed++; $display("FAIL jalr_103 got=%h exp=%h", snap(), e); end
        clear_redirect();
        @(negedge clk);
        e = pack(32'h104, 32'h100, 32'h104, mem_word(32'h100), 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL jalr_pulse_end got=%h exp=%h", snap(), e); end
        npc_op = 3'b100; ex_alu_out = 32'h101;
        @(negedge clk);
        e = pack(32'h100, 32'h100, 32'h104, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL jalr_101 got=%h exp=%h", snap(), e); end
        clear_redirect();
    endtask

    task automatic test_priority();
        npc_op = 3'b110; ex_alu_out = 32'h201; ex_pc = 32'h10; ex_imm = 32'h30;
        @(negedge clk);
        e = pack(32'h200, 32'h100, 32'h104, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL prio_jalr got=%h exp=%h", snap(), e); end
        npc_op = 3'b011; ex_pc = 32'h1000; ex_imm = 32'h6;
        @(negedge clk);
        e = pack(32'h1004, 32'h100, 32'h104, 32'h13, 1'b0, 1'b1);
        tests++; if (snap() !== e) begin failed++; $display("FAIL prio_jal got=%h exp=%h", snap(), e); end
        clear_redirect();
    endtask

    task automatic test_wrap();
        npc_op = 3'b010; ex_pc = 32'h0; ex_imm = 32'hFFFF_FFFC;
        @(negedge clk);
        e = pack(32'hFFFF_FFFC, 32'h100, 32'h104, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL wrap_jal got=%h exp=%h", snap(), e); end
        clear_redirect();
        @(negedge clk);
        e = pack(32'h0, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL wrap_seq got=%h exp=%h", snap(), e); end
    endtask

    task automatic test_imem_wait();
        npc_op = 3'b010; ex_pc = 32'h1C; ex_imm = 32'h0;
        @(negedge clk);
        clear_redirect();
        @(negedge clk);
        e = pack(32'h20, 32'h1C, 32'h20, mem_word(32'h1C), 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL wait_pre got=%h exp=%h", snap(), e); end
        imem_ready = 1'b0;
        @(negedge clk);
        e = pack(32'h20, 32'h1C, 32'h20, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL wait_bubble got=%h exp=%h", snap(), e); end
        imem_ready = 1'b1;
        @(negedge clk);
        e = pack(32'h24, 32'h20, 32'h24, mem_word(32'h20), 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL wait_resume got=%h exp=%h", snap(), e); end
    endtask

    task automatic test_async_reset();
        npc_op = 3'b100; ex_alu_out = 32'h4B;
        @(posedge clk); #1;
        e = pack(32'h48, 32'h20, 32'h24, 32'h13, 1'b0, 1'b1);
        tests++; if (snap() !== e) begin failed++; $display("FAIL async_pre got=%h exp=%h", snap(), e); end
        clear_redirect();
        #2 rstn = 1'b0;
        #1;
        e = pack(32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL async_reset got=%h exp=%h", snap(), e); end
        @(negedge clk);
        rstn = 1'b1; npc_op = 3'b010; ex_pc = 32'h40; ex_imm = 32'h10;
        @(negedge clk);
        e = pack(32'h50, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL redirect_first got=%h exp=%h", snap(), e); end
        clear_redirect();
        @(negedge clk);
        e = pack(32'h54, 32'h50, 32'h54, mem_word(32'h50), 1'b1, 1'b0);
        tests++; if (snap() !== e) begin failed++; $display("FAIL redirect_first_seq got=%h exp=%h", snap(), e); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_over_stall();
        test_jalr_align();
        test_priority();
        test_wrap();
        test_imem_wait();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired: tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the pipelined RV32I core.
- Holds the PC and drives the instruction-memory address.
- Registers each fetched instruction into the IF/ID pipeline register, which feeds the decoder and control unit.
- Consumes the NPCOp encoding produced by the control decoder: 000 sequential, 001 branch taken, 010 jal, 100 jalr. Applies redirects coming back from EX, plus stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising-edge.
- rstn  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- npc_op  in  3  NPCOp from EX stage; one-hot or zero.
- ex_pc  in  32  PC of the instruction in EX.
- ex_imm  in  32  sign-extended branch/jal offset of the EX instruction.
- ex_alu_out  in  32  rs1+imm for jalr.
- imem_ready  in  1  instruction memory has valid data this cycle.
- imem_rdata  in  32  instruction word at imem_addr.
- imem_addr  out  32  fetch address (equal to pc).
- pc  out  32  current fetch PC.
- if_id_pc  out  32  PC of instruction in IF/ID.
- if_id_pc4  out  32  if_id_pc+4, for jal/jalr link.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- pc_misalign  out  1  one-cycle pulse: redirect target had [1:0]!=00.

Behaviour:
- Reset (rstn=0, asynchronous): pc=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, pc_misalign=0. Reset mid-fetch discards everything.
- imem_addr = pc, combinational. imem_rdata is sampled at the same rising edge the PC advances (zero-wait memory when imem_ready=1).
- Redirect target, combinational:
  - npc_op[2]: {ex_alu_out[31:1],1'b0}
  - else npc_op[1]: ex_pc+ex_imm
  - else npc_op[0]: ex_pc+ex_imm
  - Priority is jalr > jal > branch if more than one bit is set (illegal, but defined).
- Target alignment: target[1:0] is forced to 00 before loading. pc_misalign=1 for the cycle after any redirect whose unforced target had bit1 set.
- Arithmetic is 32-bit modulo 2^32. pc 32'hFFFF_FFFC +4 wraps to 0. The branch add wraps identically.
- Per-edge priority, highest first:
  1. redirect (npc_op!=0): pc<=target; IF/ID<=bubble (instr=NOP_INSTR, valid=0, pc fields keep old value). Overrides stall and imem_ready.
  2. stall=1: pc and all IF/ID outputs hold.
  3. imem_ready=0: pc holds; IF/ID<=bubble.
  4. normal: pc<=pc+4; if_id_pc<=pc; if_id_pc4<=pc+4; if_id_instr<=imem_rdata; if_id_valid<=1.
- Latency: an instruction appears in IF/ID one cycle after its address is on imem_addr.
- Redirect penalty: the instruction being fetched in the redirect cycle is discarded. The younger instruction already in IF/ID is flushed by this block. The ID/EX flush is the hazard unit's job.
- Redirect in the first cycle after reset is legal and takes effect normally.
- No state machine beyond PC/IF/ID registers; the priority logic above is the complete next-state function.

Test Plan:
- Reset release, imem returns 0x00500093,0x00100113,… at 0,4,… with imem_ready=1 → if_id_pc sequence 0,4,8; if_id_valid rises 1 cycle after rstn; if_id_pc4 = if_id_pc+4.
- stall=1 for 2 cycles at pc=0x8 → pc stays 0x8 and if_id_pc stays 0x4 for both cycles, then fetch resumes at 0x8 with no instruction lost or duplicated.
- npc_op=001, ex_pc=0x10, ex_imm=0xFFFFFFF0 while stall=1 → pc=0x0 next edge; if_id_instr=0x00000013, if_id_valid=0.
- npc_op=100, ex_alu_out=0x00000103 → pc=0x100; pc_misalign pulses 1 for one cycle. Separately, ex_alu_out=0x101 → pc=0x100, pc_misalign stays 0.
- Force pc to 0xFFFFFFFC via jal (ex_pc=0, ex_imm=0xFFFFFFFC), then run sequentially → next pc=0x0; if_id_pc=0xFFFFFFFC; if_id_pc4=0x0.
- imem_ready=0 for one cycle at pc=0x20 → pc held at 0x20, bubble in IF/ID. Assert rstn=0 mid-run → all outputs reach their reset values immediately, without waiting for a clock edge.
